// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls bytes from an upstream 8-entry FIFO with a registered read port and
//   transmits each one as an 8N1 UART frame. The line idles high. When
//   another byte is waiting at the end of a stop bit, the next frame follows
//   with no idle bit in between.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   empty_i      in   upstream FIFO empty flag
//   data_i       in   upstream FIFO read data, valid the cycle after rd_en_o
//   rd_en_o      out  one-cycle read strobe to the upstream FIFO
//   tx_o         out  serial line, 8N1, idle high
//   busy_o       out  high whenever a frame is being fetched or sent
//   frame_done_o out  one-cycle pulse on the last cycle of each stop bit
//
// Parameter
//   CLKS_PER_BIT clock cycles per serial bit, 2..65535
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty_i,
  input  logic [7:0] data_i,
  output logic       rd_en_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_bit_end;
  logic             w_in_bit;

  // The baud counter only ever reaches CNT_MAX, so a bit ends there and the
  // counter never wraps inside a bit.
  assign w_bit_end = (r_baud == CNT_MAX);
  assign w_in_bit  = (r_state == START) || (r_state == DATA) || (r_state == STOP);

  // NOTE: every signal assigned in an always_comb gets a default before the
  // case statement; a path that leaves one unassigned infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (!empty_i) w_next = FETCH;
      FETCH: w_next = LOAD;
      LOAD:  w_next = START;
      START: if (w_bit_end) w_next = DATA;
      DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = STOP;
      STOP:  if (w_bit_end) w_next = empty_i ? IDLE : FETCH;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state <= w_next;

      if (w_in_bit && !w_bit_end) r_baud <= r_baud + 1'b1;
      else                        r_baud <= '0;

      // A 3-bit index rolls 7 -> 0 on its own as DATA hands over to STOP.
      if (r_state != DATA)   r_bit_idx <= '0;
      else if (w_bit_end)    r_bit_idx <= r_bit_idx + 3'd1;

      // data_i is the registered FIFO output, valid only while in LOAD.
      if (r_state == LOAD)                   r_shift <= data_i;
      else if ((r_state == DATA) && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Outputs are decoded from state and registers only; no input reaches an
  // output combinationally.
  always_comb begin
    tx_o = 1'b1;
    case (r_state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = r_shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign rd_en_o      = (r_state == FETCH);
  assign busy_o       = (r_state != IDLE);
  assign frame_done_o = (r_state == STOP) && w_bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx. Two instances run side by side, one at
//   CLKS_PER_BIT=4 and one at CLKS_PER_BIT=2; a selector routes the active
//   instance's inputs and outputs. Inputs change and outputs are sampled on
//   the falling clock edge.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty4, empty2;
  logic [7:0] data4, data2;
  logic       rd4, tx4, busy4, fd4;
  logic       rd2, tx2, busy2, fd2;
  logic       use2;
  logic       m_rd, m_tx, m_busy, m_fd;
  int         total = 0;
  int         bad   = 0;
  int         rd_cnt4 = 0;
  int         rd_cnt2 = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .empty_i(empty4), .data_i(data4),
    .rd_en_o(rd4), .tx_o(tx4), .busy_o(busy4), .frame_done_o(fd4)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .empty_i(empty2), .data_i(data2),
    .rd_en_o(rd2), .tx_o(tx2), .busy_o(busy2), .frame_done_o(fd2)
  );

  assign m_rd   = use2 ? rd2   : rd4;
  assign m_tx   = use2 ? tx2   : tx4;
  assign m_busy = use2 ? busy2 : busy4;
  assign m_fd   = use2 ? fd2   : fd4;

  always @(posedge clk) begin
    if (rd4) rd_cnt4 <= rd_cnt4 + 1;
    if (rd2) rd_cnt2 <= rd_cnt2 + 1;
  end

  task automatic set_empty(input logic v);
    if (use2) empty2 = v;
    else      empty4 = v;
  endtask

  task automatic set_data(input logic [7:0] v);
    if (use2) data2 = v;
    else      data4 = v;
  endtask

  // Samples one idle cycle, then offers byte b; the next sample is FETCH.
  task automatic start_frame(input logic [7:0] b, input string name);
    logic [3:0] got;
    @(negedge clk);
    got = {m_rd, m_tx, m_busy, m_fd};
    total++;
    if (got !== 4'b0100) begin
      bad++;
      $display("FAIL %s pre-idle: rd/tx/busy/done got %b want 0100", name, got);
    end
    set_empty(1'b0);
    set_data(b);
  endtask

  // Walks FETCH, LOAD and the 10 bit times cycle by cycle. i=0 is FETCH.
  // next_data is presented after capture; next_empty is applied at the start
  // of STOP so it is what the last STOP cycle sees.
  task automatic run_frame(input logic [7:0] b, input int cpb, input string name,
                           input logic toggle, input logic next_empty,
                           input logic [7:0] next_data);
    logic [3:0] got, exp;
    logic       etx;
    int         j;
    for (int i = 0; i < 2 + 10 * cpb; i++) begin
      @(negedge clk);
      j = i - 2;
      if (j < 0)            etx = 1'b1;
      else if (j < cpb)     etx = 1'b0;
      else if (j < 9 * cpb) etx = b[(j - cpb) / cpb];
      else                  etx = 1'b1;
      exp = {(i == 0), etx, 1'b1, (j == 10 * cpb - 1)};
      got = {m_rd, m_tx, m_busy, m_fd};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: rd/tx/busy/done got %b want %b", name, i, got, exp);
      end
      if (i == 3) set_data(next_data);
      if (toggle && (j >= cpb) && (j < 9 * cpb)) set_empty(logic'(j % 2));
      if (i == 2 + 9 * cpb) set_empty(next_empty);
    end
  endtask

  task automatic expect_idle(input int n, input string name);
    logic [3:0] got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {m_rd, m_tx, m_busy, m_fd};
      total++;
      if (got !== 4'b0100) begin
        bad++;
        $display("FAIL %s idle %0d: rd/tx/busy/done got %b want 0100", name, i, got);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    use2 = 1'b0;
    empty4 = 1'b0; empty2 = 1'b0;      // reset must win over a non-empty FIFO
    data4 = 8'hFF; data2 = 8'hFF;
    repeat (3) @(negedge clk);
    total++;
    if ({rd4, tx4, busy4, fd4} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_cpb4: rd/tx/busy/done got %b want 0100", {rd4, tx4, busy4, fd4});
    end
    total++;
    if ({rd2, tx2, busy2, fd2} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_cpb2: rd/tx/busy/done got %b want 0100", {rd2, tx2, busy2, fd2});
    end
    empty4 = 1'b1; empty2 = 1'b1;
    rst = 1'b0;
    expect_idle(2, "post_reset");
  endtask

  task automatic test_single_byte();
    int base;
    use2 = 1'b0;
    base = rd_cnt4;
    start_frame(8'hA5, "single");
    run_frame(8'hA5, 4, "single", 1'b0, 1'b1, 8'h00);
    expect_idle(4, "single_after");
    total++;
    if (rd_cnt4 - base !== 1) begin
      bad++;
      $display("FAIL single rd_en pulses: got %0d want 1", rd_cnt4 - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    use2 = 1'b0;
    base = rd_cnt4;
    start_frame(8'h00, "b2b");
    run_frame(8'h00, 4, "b2b_first", 1'b0, 1'b0, 8'hFF);
    run_frame(8'hFF, 4, "b2b_second", 1'b0, 1'b1, 8'h00);
    expect_idle(8, "b2b_after");
    total++;
    if (rd_cnt4 - base !== 2) begin
      bad++;
      $display("FAIL b2b rd_en pulses: got %0d want 2", rd_cnt4 - base);
    end
  endtask

  task automatic test_empty();
    int base;
    use2 = 1'b0;
    base = rd_cnt4;
    set_empty(1'b1);
    expect_idle(100, "empty");
    total++;
    if (rd_cnt4 - base !== 0) begin
      bad++;
      $display("FAIL empty rd_en pulses: got %0d want 0", rd_cnt4 - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int         base;
    logic [3:0] got;
    use2 = 1'b0;
    base = rd_cnt4;
    start_frame(8'h3C, "midrst");
    // i=18 is the first cycle of data bit 3 (bit 3 occupies i=18..21).
    repeat (19) @(negedge clk);
    total++;
    if (m_busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst busy before reset: got %b want 1", m_busy);
    end
    rst = 1'b1;
    set_empty(1'b0);
    set_data(8'h5A);
    @(negedge clk);
    rst = 1'b0;
    got = {m_rd, m_tx, m_busy, m_fd};
    total++;
    if (got !== 4'b0100) begin
      bad++;
      $display("FAIL midrst after reset: rd/tx/busy/done got %b want 0100", got);
    end
    total++;
    if (rd_cnt4 - base !== 1) begin
      bad++;
      $display("FAIL midrst rd_en pulses: got %0d want 1", rd_cnt4 - base);
    end
    // empty_i stayed low through reset, so the next edge starts a new frame.
    run_frame(8'h5A, 4, "midrst_next", 1'b0, 1'b1, 8'h00);
    expect_idle(3, "midrst_after");
  endtask

  task automatic test_empty_toggle();
    int base;
    use2 = 1'b0;
    base = rd_cnt4;
    start_frame(8'h96, "toggle");
    run_frame(8'h96, 4, "toggle", 1'b1, 1'b1, 8'h00);
    expect_idle(4, "toggle_after");
    total++;
    if (rd_cnt4 - base !== 1) begin
      bad++;
      $display("FAIL toggle rd_en pulses: got %0d want 1", rd_cnt4 - base);
    end
  endtask

  task automatic test_timing_cpb2();
    int n, fd_n, low_n;
    use2 = 1'b1;
    start_frame(8'hC3, "cpb2");
    run_frame(8'hC3, 2, "cpb2", 1'b0, 1'b1, 8'h00);
    expect_idle(3, "cpb2_after");
    // Count cycles with the idle cycle that first sees empty_i low as n=1.
    start_frame(8'h81, "cpb2_len");
    n = 1; fd_n = 0; low_n = 0;
    while ((fd_n == 0) && (n < 200)) begin
      @(negedge clk);
      n++;
      if ((m_tx === 1'b0) && (low_n == 0)) low_n = n;
      if (m_fd === 1'b1) fd_n = n;
    end
    set_empty(1'b1);
    total++;
    if (fd_n !== 23) begin
      bad++;
      $display("FAIL cpb2 frame length: got %0d want 23", fd_n);
    end
    total++;
    if (low_n - 1 !== 3) begin
      bad++;
      $display("FAIL cpb2 start latency: got %0d want 3", low_n - 1);
    end
    expect_idle(3, "cpb2_len_after");
    use2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_reset_mid_frame();
    test_empty_toggle();
    test_timing_cpb2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
